// File: rtl/sample_pos_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// sample_pos_sequencer_pkg
// Shared definitions for the harmonic sample-position sequencer:
//   - sweep state encoding (IDLE, READ, WRITE, FINISH)
//   - default address/data widths
//   - NYQUIST constant (half of the position range for the default width)
//     and a helper that produces it for any data width
// ---------------------------------------------------------------------------
package sample_pos_sequencer_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int NYQUIST        = 2 ** (DEF_DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Half-range threshold for a position of width dw.
    function automatic int unsigned nyquist_of(input int unsigned dw);
        return 32'd1 << (dw - 1);
    endfunction

endpackage

// File: rtl/sample_pos_sequencer_if.sv
// ---------------------------------------------------------------------------
// sample_pos_sequencer_if
// Bundles the sweep request inputs, the phase-RAM port and the downstream
// position stream of the sequencer.
//   slave  : the sequencer (consumes the strobe, drives RAM and outputs)
//   master : the surrounding system (strobe source, RAM read data, sink)
// Optional: HARD_SYNC_EN adds the hard_sync request line.
// ---------------------------------------------------------------------------
interface sample_pos_sequencer_if
    import sample_pos_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  sample_start;
    logic [DATA_WIDTH-1:0] freq_inc;
    logic [ADDR_WIDTH:0]   harm_count;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic [DATA_WIDTH-1:0] pos_out;
    logic                  pos_valid;
    logic [ADDR_WIDTH-1:0] harm_index;
    logic                  busy;
    logic                  done;
    logic                  overrun;
`ifdef HARD_SYNC_EN
    logic                  hard_sync;
`endif

    modport slave (
        input  sample_start, freq_inc, harm_count, ram_dout,
`ifdef HARD_SYNC_EN
        input  hard_sync,
`endif
        output ram_addr, ram_din, ram_we, pos_out, pos_valid, harm_index,
               busy, done, overrun
    );

    modport master (
        output sample_start, freq_inc, harm_count, ram_dout,
`ifdef HARD_SYNC_EN
        output hard_sync,
`endif
        input  ram_addr, ram_din, ram_we, pos_out, pos_valid, harm_index,
               busy, done, overrun
    );
endinterface

// File: rtl/sample_pos_sequencer_harmonic_inc_gen.sv
// ---------------------------------------------------------------------------
// harmonic_inc_gen
// Produces the phase increment of the current harmonic, (n+1)*fundamental,
// by repeated accumulation, and flags when the next harmonic would reach
// the Nyquist threshold.
//   clk, reset_n     : clock, asynchronous active-low reset
//   i_load           : start of sweep, latch i_freq_inc (harmonic 0)
//   i_freq_inc       : fundamental increment
//   i_step           : advance to the next harmonic
//   o_inc            : increment of the current harmonic
//   o_nyquist_hit    : next harmonic's increment >= half range
// ---------------------------------------------------------------------------
module harmonic_inc_gen
    import sample_pos_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_freq_inc,
    input  logic                  i_step,
    output logic [DATA_WIDTH-1:0] o_inc,
    output logic                  o_nyquist_hit
);
    localparam logic [DATA_WIDTH:0] NYQ = {2'b01, {(DATA_WIDTH-1){1'b0}}};

    // One extra bit so the first increment past Nyquist is still visible.
    // The accumulator is below NYQ whenever it steps, so it cannot overflow.
    logic [DATA_WIDTH:0]   r_inc_acc;
    logic [DATA_WIDTH-1:0] r_freq;
    logic [DATA_WIDTH:0]   w_inc_next;

    assign w_inc_next    = r_inc_acc + {1'b0, r_freq};
    assign o_inc         = r_inc_acc[DATA_WIDTH-1:0];
    assign o_nyquist_hit = (w_inc_next >= NYQ);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inc_acc <= '0;
            r_freq    <= '0;
        end else if (i_load) begin
            r_inc_acc <= {1'b0, i_freq_inc};
            r_freq    <= i_freq_inc;
        end else if (i_step) begin
            r_inc_acc <= w_inc_next;
        end
    end
endmodule

// File: rtl/sample_pos_sequencer.sv
// ---------------------------------------------------------------------------
// sample_pos_sequencer
// Once per audio sample, walks harmonics 0..N-1 of the phase RAM: reads the
// stored position, adds (n+1)*fundamental, writes it back and presents it to
// the downstream stage. Two cycles per harmonic; stops early at Nyquist.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : sample_start/freq_inc/harm_count request, RAM port
//                  (ram_addr/ram_din/ram_we out, ram_dout in), pos_out/
//                  pos_valid/harm_index stream, busy/done/overrun status
// Optional: HARD_SYNC_EN adds bus.hard_sync; a pending hard sync makes the
// next accepted sweep treat every stored position as zero.
// ---------------------------------------------------------------------------
module sample_pos_sequencer
    import sample_pos_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sample_pos_sequencer_if.slave bus
);
    localparam logic [ADDR_WIDTH:0]   LIM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH:0]   r_limit;
    logic [DATA_WIDTH-1:0] r_sum;
    logic [DATA_WIDTH-1:0] r_pos_out;
    logic                  r_pos_valid;
    logic [ADDR_WIDTH-1:0] r_harm_index;
    logic                  r_busy, r_done, r_overrun;

    logic                  w_inc_load, w_inc_step, w_nyq, w_last, w_zero_base;
    logic [DATA_WIDTH-1:0] w_inc, w_base, w_sum;

    harmonic_inc_gen #(.DATA_WIDTH(DATA_WIDTH)) u_inc_gen (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_load        (w_inc_load),
        .i_freq_inc    (bus.freq_inc),
        .i_step        (w_inc_step),
        .o_inc         (w_inc),
        .o_nyquist_hit (w_nyq)
    );

`ifdef HARD_SYNC_EN
    logic r_hs_pending, r_hs_sweep;

    // The sweep decides at acceptance whether it is a hard-synced one; the
    // pending request is consumed when that sweep finishes (unless a fresh
    // request arrives in that very cycle).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_pending <= 1'b0;
            r_hs_sweep   <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && bus.sample_start)
                r_hs_sweep <= r_hs_pending | bus.hard_sync;
            if (r_state == ST_FINISH && r_hs_sweep)
                r_hs_pending <= bus.hard_sync;
            else if (bus.hard_sync)
                r_hs_pending <= 1'b1;
        end
    end
    assign w_zero_base = r_hs_sweep;
`else
    assign w_zero_base = 1'b0;
`endif

    assign w_base = w_zero_base ? '0 : bus.ram_dout;
    assign w_sum  = w_base + w_inc;
    assign w_last = (({1'b0, r_idx} + LIM_ONE) == r_limit);

    // RAM port decodes directly from registered state so reset drops the
    // write enable immediately.
    assign bus.ram_addr   = r_idx;
    assign bus.ram_din    = r_sum;
    assign bus.ram_we     = (r_state == ST_WRITE);
    assign bus.pos_out    = r_pos_out;
    assign bus.pos_valid  = r_pos_valid;
    assign bus.harm_index = r_harm_index;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.overrun    = r_overrun;

    always_comb begin
        w_state_next = r_state;
        w_inc_load   = 1'b0;
        w_inc_step   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.sample_start) begin
                    w_inc_load = 1'b1;
                    // Fundamental already at/above Nyquist: nothing to do.
                    if (bus.harm_count == '0 || bus.freq_inc[DATA_WIDTH-1])
                        w_state_next = ST_FINISH;
                    else
                        w_state_next = ST_READ;
                end
            end
            ST_READ:  w_state_next = ST_WRITE;
            ST_WRITE: begin
                w_inc_step   = 1'b1;
                w_state_next = (w_last || w_nyq) ? ST_FINISH : ST_READ;
            end
            ST_FINISH: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_limit      <= '0;
            r_sum        <= '0;
            r_pos_out    <= '0;
            r_pos_valid  <= 1'b0;
            r_harm_index <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_busy      <= (w_state_next != ST_IDLE);
            r_done      <= (w_state_next == ST_FINISH);
            // Output stream is loaded in READ so it is valid during WRITE.
            r_pos_valid <= (r_state == ST_READ);
            if (r_state == ST_READ) begin
                r_sum        <= w_sum;
                r_pos_out    <= w_sum;
                r_harm_index <= r_idx;
            end
            if (r_state == ST_IDLE && bus.sample_start) begin
                r_idx   <= '0;
                r_limit <= bus.harm_count;
            end else if (r_state == ST_WRITE) begin
                r_idx <= r_idx + IDX_ONE;
            end
            if (bus.sample_start && r_state != ST_IDLE)
                r_overrun <= 1'b1;
        end
    end
endmodule

// File: doc/sample_pos_sequencer.md
Name: sample_pos_sequencer

Overview:
Sequences the per-harmonic sample-position (phase accumulator) RAM once per audio sample.
- On each sample strobe, walks harmonics 0..N-1: reads the stored position, adds that harmonic's phase increment ((n+1)·fundamental), writes the result back, and presents it to the downstream sine-lookup/mix stage.
- Stops early at the Nyquist limit.
- Sole owner of the RAM address/write ports.

Parameters:
ADDR_WIDTH, 8, RAM address width; maximum harmonic count is 2^ADDR_WIDTH
DATA_WIDTH, 16, position/increment width; positions wrap modulo 2^DATA_WIDTH

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sample_start  in  1  one-cycle strobe that begins a harmonic sweep
freq_inc  in  DATA_WIDTH  fundamental phase increment; sampled at sample_start
harm_count  in  ADDR_WIDTH+1  harmonics to process (0..2^ADDR_WIDTH); sampled at sample_start
ram_addr  out  ADDR_WIDTH  RAM address
ram_din  out  DATA_WIDTH  RAM write data
ram_we  out  1  RAM write enable
ram_dout  in  DATA_WIDTH  RAM read data (combinational read of ram_addr)
pos_out  out  DATA_WIDTH  updated position for current harmonic
pos_valid  out  1  pos_out/harm_index valid this cycle
harm_index  out  ADDR_WIDTH  harmonic number of pos_out
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at sweep end
overrun  out  1  sticky: sample_start arrived while busy

Behaviour:
- Reset values (asynchronous, reset_n=0): state IDLE; all outputs 0; internal index/increment registers 0. RAM contents are not cleared.
- States:
  - IDLE: sample_start=1 → latch freq_inc to inc_acc (DATA_WIDTH+1 bits) and harm_count to limit; idx=0.
    - If harm_count=0 or freq_inc ≥ 2^(DATA_WIDTH-1): → FINISH.
    - Else → READ.
  - READ: ram_addr=idx, ram_we=0; register sum = (ram_dout + inc_acc[DATA_WIDTH-1:0]) mod 2^DATA_WIDTH → WRITE.
  - WRITE: ram_addr=idx, ram_din=sum, ram_we=1, pos_out=sum, harm_index=idx, pos_valid=1. Then inc_acc += freq_inc_latched and idx += 1.
    - If idx+1 == limit or next inc_acc ≥ 2^(DATA_WIDTH-1) (Nyquist): → FINISH.
    - Else → READ.
  - FINISH: done=1 for one cycle → IDLE.
- Throughput and latency: 2 cycles per harmonic. Strobe at cycle 0 → first ram_we/pos_valid at cycle 2 → done at cycle 2N+1 for N harmonics.
- busy=1 in READ/WRITE/FINISH.
- ram_we is asserted only in WRITE; only harmonics < limit are ever written.
- sample_start while busy: ignored, and overrun set. overrun clears only on reset.
- Simultaneous sample_start with the FINISH cycle: counts as busy (ignored, overrun set).
- Inputs changed mid-sweep: no effect until the next accepted start.
- Reset asserted mid-sweep: ram_we drops immediately (asynchronous); the partially swept RAM keeps its values.
- Maximum sweep: harm_count=2^ADDR_WIDTH; idx wraps only after the final write.
- All outputs are registered except ram_addr/ram_din/ram_we, which decode from registered state/idx/sum.

Optional Feature:
HARD_SYNC_EN
- Defined: adds input hard_sync (1 bit), latched as pending when high in any state.
  - The next accepted sweep writes sum = inc_acc (position treated as 0) for every harmonic processed.
  - Pending clears at that sweep's FINISH.
  - hard_sync coincident with an accepted sample_start applies to that same sweep.
- Undefined: port absent; sum always uses ram_dout.

Decomposition:
- Shared package: state encoding (IDLE, READ, WRITE, FINISH), default ADDR_WIDTH/DATA_WIDTH, and NYQUIST constant = 2^(DATA_WIDTH-1).
- Sub-module harmonic_inc_gen is natural: holds inc_acc, accumulates freq_inc, flags nyquist_hit.
- The RAM itself is instantiated beside this block, not inside it.

Test Plan:
1. Reset, RAM zero, freq_inc=0x0100, harm_count=4, start → writes idx0..3 = 0x0100, 0x0200, 0x0300, 0x0400; done at cycle 9; second start → 0x0200, 0x0400, 0x0600, 0x0800.
2. freq_inc=0x3000, harm_count=8 → only idx0 (0x3000) and idx1 (0x6000) written; third increment 0x9000 ≥ 0x8000 stops sweep; done after 2 writes.
3. RAM idx0=0xFF80, freq_inc=0x0100, harm_count=1 → pos_out=0x0080 (wrap); harm_count=0 → done at cycle 1, ram_we never high.
4. Second sample_start at cycle 3 of a 4-harmonic sweep → ignored, overrun=1 until reset; sweep completes unchanged.
5. reset_n low during a WRITE cycle → ram_we=0 that same cycle, busy=0; next start sweeps normally from the RAM's current values.
6. (HARD_SYNC_EN) RAM idx0..1 = 0x1234, 0x5678; hard_sync pulse, freq_inc=0x0010, harm_count=2 → writes 0x0010, 0x0020; following sweep → 0x0020, 0x0040.
